// File: rtl/hit_judge_pkg.sv
// Shared grade encoding, score weights and the offset-to-grade rule for the hit judge.
package hit_judge_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PERFECT = 2'd1,
    GOOD    = 2'd2,
    MISS    = 2'd3
  } grade_e;

  localparam int unsigned PTS_PERFECT = 3;
  localparam int unsigned PTS_GOOD    = 1;

  // Offsets beyond the good window grade as NONE: the press is simply ignored.
  function automatic grade_e grade_of(input int unsigned offset,
                                      input int unsigned perfect_win,
                                      input int unsigned good_win);
    grade_e g;
    g = NONE;
    if (offset <= perfect_win) begin
      g = PERFECT;
    end else if (offset <= good_win) begin
      g = GOOD;
    end
    return g;
  endfunction

endpackage

// File: rtl/hit_judge_lane_judge.sv
// One lane: key edge detect, note travel shift register, late flag and grade selection.
// The grade is combinational from pre-update state; the top registers it.
module lane_judge
  import hit_judge_pkg::*;
#(
  parameter int unsigned TRAVEL_STEPS = 11,
  parameter int unsigned STEP_FRAMES  = 5,
  parameter int unsigned PERFECT_WIN  = 1,
  parameter int unsigned GOOD_WIN     = 2,
  parameter int unsigned PHASE_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_i,
  input  logic               miss_tick_i,
  input  logic [PHASE_W-1:0] phase_i,
  input  logic               note_i,
  input  logic               key_i,
  output grade_e             grade_o
);

  logic [TRAVEL_STEPS-1:0] pending_q, pending_d, pending_kept;
  logic                    late_q, late_d;
  logic                    key_q;
  logic                    press;
  logic                    take_late, take_early;
  grade_e                  late_grade, early_grade;

  always_comb begin
    press       = key_i & ~key_q;
    late_grade  = NONE;
    early_grade = NONE;
    if (late_q) begin
      late_grade = grade_of(32'(phase_i), PERFECT_WIN, GOOD_WIN);
    end
    if (pending_q[TRAVEL_STEPS-1]) begin
      early_grade = grade_of(STEP_FRAMES - 32'(phase_i), PERFECT_WIN, GOOD_WIN);
    end

    // A press on a judgeable note beats a miss tick in the same cycle.
    grade_o    = NONE;
    take_late  = 1'b0;
    take_early = 1'b0;
    if (press && late_grade != NONE) begin
      grade_o   = late_grade;
      take_late = 1'b1;
    end else if (press && early_grade != NONE) begin
      grade_o    = early_grade;
      take_early = 1'b1;
    end else if (miss_tick_i && late_q) begin
      grade_o   = MISS;
      take_late = 1'b1;
    end

    pending_kept = pending_q;
    if (take_early) begin
      pending_kept[TRAVEL_STEPS-1] = 1'b0;
    end
    pending_d = pending_kept;
    late_d    = late_q & ~take_late;
    if (step_i) begin
      pending_d = {pending_kept[TRAVEL_STEPS-2:0], note_i};
      late_d    = late_d | pending_kept[TRAVEL_STEPS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      late_q    <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      late_q    <= late_d;
      key_q     <= key_i;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: frame phase and scroll step, per-lane judging, score and combo.
// step is combinational with frame_tick; result pulses and tallies are registered one clk later.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned TRAVEL_STEPS = 11,
  parameter int unsigned STEP_FRAMES  = 5,
  parameter int unsigned PERFECT_WIN  = 1,
  parameter int unsigned GOOD_WIN     = 2,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned COMBO_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [LANES-1:0]   note,
  input  logic [LANES-1:0]   key,
  output logic               step,
  output logic [LANES-1:0]   hit_perfect,
  output logic [LANES-1:0]   hit_good,
  output logic [LANES-1:0]   miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo
);

  localparam int unsigned PHASE_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned CNT_W   = $clog2(LANES + 1);
  localparam int unsigned SSUM_W  = SCORE_W + 1;
  localparam int unsigned CSUM_W  = COMBO_W + 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STEP_FRAMES - 1);
  localparam logic [PHASE_W-1:0] PHASE_MISS = PHASE_W'(GOOD_WIN);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               miss_tick;
  grade_e             lane_grade [LANES];

  logic [LANES-1:0]   perfect_d, good_d, miss_d;
  logic [LANES-1:0]   perfect_q, good_q, miss_q;
  logic [CNT_W-1:0]   n_perfect, n_good;
  logic [SSUM_W-1:0]  score_sum;
  logic [CSUM_W-1:0]  combo_sum;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d, max_q, max_d;

  assign step      = ~reset & frame_tick & (phase_q == PHASE_LAST);
  assign miss_tick = frame_tick & (phase_q == PHASE_MISS);

  always_comb begin
    phase_d = phase_q;
    if (frame_tick) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(
      .TRAVEL_STEPS (TRAVEL_STEPS),
      .STEP_FRAMES  (STEP_FRAMES),
      .PERFECT_WIN  (PERFECT_WIN),
      .GOOD_WIN     (GOOD_WIN),
      .PHASE_W      (PHASE_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .step_i      (step),
      .miss_tick_i (miss_tick),
      .phase_i     (phase_q),
      .note_i      (note[g]),
      .key_i       (key[g]),
      .grade_o     (lane_grade[g])
    );
  end

  always_comb begin
    perfect_d = '0;
    good_d    = '0;
    miss_d    = '0;
    n_perfect = '0;
    n_good    = '0;
    for (int i = 0; i < LANES; i++) begin
      perfect_d[i] = (lane_grade[i] == PERFECT);
      good_d[i]    = (lane_grade[i] == GOOD);
      miss_d[i]    = (lane_grade[i] == MISS);
      n_perfect    = n_perfect + CNT_W'(perfect_d[i]);
      n_good       = n_good + CNT_W'(good_d[i]);
    end

    score_sum = {1'b0, score_q} + SSUM_W'(PTS_PERFECT) * SSUM_W'(n_perfect)
              + SSUM_W'(PTS_GOOD) * SSUM_W'(n_good);
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    // Any miss breaks the chain and discards hits landing in the same cycle.
    combo_sum = {1'b0, combo_q} + CSUM_W'(n_perfect) + CSUM_W'(n_good);
    if (|miss_d) begin
      combo_d = '0;
    end else begin
      combo_d = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end
    max_d = (combo_d > max_q) ? combo_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      perfect_q <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      score_q   <= '0;
      combo_q   <= '0;
      max_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      perfect_q <= perfect_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
    end
  end

  assign hit_perfect = perfect_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios against fixed values, then random play against a frame-time model.
module tb_hit_judge;

  localparam int LANES         = 4;
  localparam int TRAVEL_STEPS  = 11;
  localparam int STEP_FRAMES   = 5;
  localparam int PERFECT_WIN   = 1;
  localparam int GOOD_WIN      = 2;
  localparam int SCORE_W       = 16;
  localparam int COMBO_W       = 8;
  localparam int TRAVEL_FRAMES = TRAVEL_STEPS * STEP_FRAMES;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic [LANES-1:0]   note = '0;
  logic [LANES-1:0]   key = '0;
  logic               step;
  logic [LANES-1:0]   hit_perfect, hit_good, miss;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo, max_combo;

  always #5 clk = ~clk;

  hit_judge #(
    .LANES(LANES), .TRAVEL_STEPS(TRAVEL_STEPS), .STEP_FRAMES(STEP_FRAMES),
    .PERFECT_WIN(PERFECT_WIN), .GOOD_WIN(GOOD_WIN), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .note(note), .key(key),
    .step(step), .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
    .score(score), .combo(combo), .max_combo(max_combo)
  );

  int checks = 0;
  int errors = 0;

  // Model: notes are absolute frame numbers at which they reach the hit line.
  int                 m_frame;
  logic [LANES-1:0]   m_prev;
  int                 m_due [LANES][$];
  logic               exp_step;
  logic [LANES-1:0]   exp_perfect, exp_good, exp_miss;
  logic [SCORE_W-1:0] exp_score;
  logic [COMBO_W-1:0] exp_combo, exp_max;

  logic               step_seen;
  int                 step_cnt;
  logic [LANES-1:0]   acc_perfect, acc_good, acc_miss;
  logic [LANES-1:0]   cur_key = '0;

  task automatic model_cycle(input bit r, input bit t, input logic [LANES-1:0] n,
                             input logic [LANES-1:0] k);
    int d, np, ng, s, c;
    bit done;
    exp_perfect = '0;
    exp_good    = '0;
    exp_miss    = '0;
    exp_step    = 1'b0;
    if (r) begin
      m_frame = 0;
      m_prev  = '0;
      for (int l = 0; l < LANES; l++) m_due[l].delete();
      exp_score = '0;
      exp_combo = '0;
      exp_max   = '0;
      return;
    end
    exp_step = t && (m_frame % STEP_FRAMES == STEP_FRAMES - 1);
    for (int l = 0; l < LANES; l++) begin
      if (k[l] && !m_prev[l]) begin
        done = 0;
        for (int j = 0; j < m_due[l].size() && !done; j++) begin
          d = m_frame - m_due[l][j];
          if (d >= -GOOD_WIN && d <= GOOD_WIN) begin
            if (d >= -PERFECT_WIN && d <= PERFECT_WIN) exp_perfect[l] = 1'b1;
            else exp_good[l] = 1'b1;
            m_due[l].delete(j);
            done = 1;
          end
        end
      end
      if (t) begin
        done = 0;
        for (int j = 0; j < m_due[l].size() && !done; j++) begin
          if (m_due[l][j] + GOOD_WIN + 1 == m_frame + 1) begin
            exp_miss[l] = 1'b1;
            m_due[l].delete(j);
            done = 1;
          end
        end
      end
      if (exp_step && n[l]) m_due[l].push_back(m_frame + 1 + TRAVEL_FRAMES);
    end
    m_prev = k;
    if (t) m_frame++;
    np = $countones(exp_perfect);
    ng = $countones(exp_good);
    s  = int'(exp_score) + 3 * np + ng;
    exp_score = (s > 65535) ? 16'hFFFF : 16'(s);
    c  = int'(exp_combo) + np + ng;
    if (exp_miss != 0) exp_combo = '0;
    else exp_combo = (c > 255) ? 8'hFF : 8'(c);
    if (exp_combo > exp_max) exp_max = exp_combo;
  endtask

  task automatic cyc(input bit r, input bit t, input logic [LANES-1:0] n,
                     input logic [LANES-1:0] k);
    @(negedge clk);
    reset = r; frame_tick = t; note = n; key = k;
    #1;
    step_seen = step;
    if (step === 1'b1) step_cnt++;
    model_cycle(r, t, n, k);
    @(posedge clk);
    #1;
    acc_perfect |= hit_perfect;
    acc_good    |= hit_good;
    acc_miss    |= miss;
  endtask

  // One frame: a tick cycle with the held key, then an idle cycle presenting the new key.
  task automatic frame(input logic [LANES-1:0] n, input logic [LANES-1:0] newkey);
    cyc(1'b0, 1'b1, n, cur_key);
    cyc(1'b0, 1'b0, '0, newkey);
    cur_key = newkey;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, cur_key);
    cyc(1'b1, 1'b0, '0, cur_key);
    acc_perfect = '0; acc_good = '0; acc_miss = '0; step_cnt = 0;
  endtask

  task automatic test_reset();
    cur_key = 4'hF;
    for (int i = 0; i < 8; i++) cyc(1'b1, i[0], 4'hF, 4'hF);
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", combo); end
    checks++; if (max_combo !== 8'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max_combo); end
    checks++; if ({hit_perfect, hit_good, miss} !== 12'd0) begin
      errors++; $display("FAIL reset_pulses: got %h want 000", {hit_perfect, hit_good, miss}); end
    checks++; if (step_cnt !== 0) begin errors++; $display("FAIL reset_step: got %0d steps want 0", step_cnt); end
    acc_perfect = '0; acc_good = '0; acc_miss = '0; step_cnt = 0;
    for (int f = 1; f <= 4; f++) frame('0, 4'hF);
    checks++; if (step_cnt !== 0) begin errors++; $display("FAIL reset_early_step: got %0d want 0", step_cnt); end
    frame('0, 4'hF);
    checks++; if (step_cnt !== 1) begin errors++; $display("FAIL reset_first_step: got %0d want 1", step_cnt); end
    checks++; if ({acc_perfect, acc_good, acc_miss} !== 12'd0) begin
      errors++; $display("FAIL reset_held_key: got %h want 000", {acc_perfect, acc_good, acc_miss}); end
    cur_key = '0;
  endtask

  task automatic test_perfect();
    do_reset();
    for (int f = 1; f <= 60; f++) frame((f == 5) ? 4'b0001 : 4'b0000, (f == 60) ? 4'b0001 : 4'b0000);
    checks++; if (hit_perfect !== 4'b0001) begin errors++; $display("FAIL perfect_pulse: got %b want 0001", hit_perfect); end
    checks++; if (score !== 16'd3) begin errors++; $display("FAIL perfect_score: got %0d want 3", score); end
    checks++; if (combo !== 8'd1 || max_combo !== 8'd1) begin
      errors++; $display("FAIL perfect_combo: got %0d/%0d want 1/1", combo, max_combo); end
    checks++; if (step_cnt !== 12) begin errors++; $display("FAIL perfect_steps: got %0d want 12", step_cnt); end
  endtask

  task automatic test_early();
    do_reset();
    for (int f = 1; f <= 58; f++) frame((f == 5) ? 4'b0001 : 4'b0000, (f == 58) ? 4'b0001 : 4'b0000);
    checks++; if (hit_good !== 4'b0001 || hit_perfect !== 4'b0000) begin
      errors++; $display("FAIL early_good: got good=%b perfect=%b want 0001/0000", hit_good, hit_perfect); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL early_score: got %0d want 1", score); end
    for (int f = 59; f <= 70; f++) frame('0, 4'b0001);
    checks++; if (acc_miss !== 4'b0000) begin errors++; $display("FAIL early_no_miss: got %b want 0000", acc_miss); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL early_score_hold: got %0d want 1", score); end
    cur_key = '0;
    do_reset();
    for (int f = 1; f <= 59; f++) frame((f == 5) ? 4'b0001 : 4'b0000, (f == 59) ? 4'b0001 : 4'b0000);
    checks++; if (hit_perfect !== 4'b0001) begin errors++; $display("FAIL early_phase4: got %b want 0001", hit_perfect); end
    checks++; if (score !== 16'd3) begin errors++; $display("FAIL early_phase4_score: got %0d want 3", score); end
    cur_key = '0;
  endtask

  task automatic test_miss();
    logic [3:0] n, k;
    do_reset();
    for (int f = 1; f <= 84; f++) begin
      n = (f % 5 == 0 && f <= 30) ? 4'b0001 : 4'b0000;
      k = (f >= 60 && f <= 80 && f % 5 == 0) ? 4'b0001 : 4'b0000;
      frame(n, k);
    end
    checks++; if (combo !== 8'd5 || score !== 16'd15) begin
      errors++; $display("FAIL miss_setup: got combo=%0d score=%0d want 5/15", combo, score); end
    for (int f = 85; f <= 87; f++) frame('0, '0);
    checks++; if (acc_miss !== 4'b0000) begin errors++; $display("FAIL miss_too_soon: got %b want 0000", acc_miss); end
    frame('0, '0);
    checks++; if (acc_miss !== 4'b0001) begin errors++; $display("FAIL miss_pulse: got %b want 0001", acc_miss); end
    checks++; if (combo !== 8'd0 || max_combo !== 8'd5) begin
      errors++; $display("FAIL miss_combo: got %0d/%0d want 0/5", combo, max_combo); end
    checks++; if (score !== 16'd15) begin errors++; $display("FAIL miss_score: got %0d want 15", score); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] n, k;
    do_reset();
    for (int f = 1; f <= 68; f++) begin
      n = (f == 5 || f == 10) ? 4'b1111 : 4'b0000;
      k = (f == 61) ? 4'b1111 : (f == 66) ? 4'b0111 : 4'b0000;
      frame(n, k);
      if (f == 61) begin
        checks++; if (hit_perfect !== 4'b1111) begin errors++; $display("FAIL chord_pulse: got %b want 1111", hit_perfect); end
        checks++; if (score !== 16'd12 || combo !== 8'd4) begin
          errors++; $display("FAIL chord_tally: got score=%0d combo=%0d want 12/4", score, combo); end
      end
    end
    checks++; if (acc_miss !== 4'b1000) begin errors++; $display("FAIL chord_miss: got %b want 1000", acc_miss); end
    checks++; if (combo !== 8'd0 || max_combo !== 8'd7) begin
      errors++; $display("FAIL chord_combo: got %0d/%0d want 0/7", combo, max_combo); end
    checks++; if (score !== 16'd21) begin errors++; $display("FAIL chord_score: got %0d want 21", score); end
  endtask

  task automatic test_stray_press();
    do_reset();
    for (int f = 1; f <= 80; f++) begin
      frame((f == 25) ? 4'b0100 : 4'b0000, (f == 20 || f == 80) ? 4'b0100 : 4'b0000);
      if (f == 79) begin
        checks++; if ({acc_perfect, acc_good, acc_miss} !== 12'd0) begin
          errors++; $display("FAIL stray_pulses: got %h want 000", {acc_perfect, acc_good, acc_miss}); end
        checks++; if (score !== 16'd0 || combo !== 8'd0) begin
          errors++; $display("FAIL stray_tally: got score=%0d combo=%0d want 0/0", score, combo); end
      end
    end
    checks++; if (hit_perfect !== 4'b0100) begin errors++; $display("FAIL stray_later_note: got %b want 0100", hit_perfect); end
    checks++; if (score !== 16'd3) begin errors++; $display("FAIL stray_later_score: got %0d want 3", score); end
    cur_key = '0;
  endtask

  task automatic test_random();
    logic [LANES-1:0] k;
    bit t, r;
    k = '0;
    cyc(1'b1, 1'b0, '0, k);
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 999) == 0);
      t = ($urandom_range(0, 1) == 1);
      for (int l = 0; l < LANES; l++) if ($urandom_range(0, 5) == 0) k[l] = ~k[l];
      cyc(r, t, 4'($urandom), k);
      checks++; if (step_seen !== exp_step) begin
        errors++; $display("FAIL rand_step c=%0d: got %b want %b", c, step_seen, exp_step); end
      checks++; if (hit_perfect !== exp_perfect || hit_good !== exp_good || miss !== exp_miss) begin
        errors++; $display("FAIL rand_pulses c=%0d: got p=%b g=%b m=%b want p=%b g=%b m=%b",
                           c, hit_perfect, hit_good, miss, exp_perfect, exp_good, exp_miss); end
      checks++; if (score !== exp_score || combo !== exp_combo || max_combo !== exp_max) begin
        errors++; $display("FAIL rand_tally c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                           c, score, combo, max_combo, exp_score, exp_combo, exp_max); end
    end
    cur_key = k;
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_early();
    test_miss();
    test_back_to_back();
    test_stray_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
